laplace_window: RTL and testbench

LAPLACE_WINDOW -- requirements
Module: laplace_window

---
 rtl/laplace_pkg.sv | 27 ++
 rtl/line_buffer.sv | 51 +++++
 rtl/laplace_window.sv | 213 +++++++++++++++++++++
 tb/tb_laplace_window.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/laplace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : laplace_pkg
// Description : Shared constants, state encoding and sizing helper for the
//               laplace_window cross-window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package laplace_pkg;

    localparam int PIX_W    = 8;
    localparam int DEF_COLS = 512;
    localparam int DEF_ROWS = 512;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter width for a modulo-n counter; never narrower than one bit so
    // degenerate sizes (n = 1) still give a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : laplace_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Enable-driven sample delay built on a circular buffer of
//               DEPTH pixel entries. Each enabled cycle writes i_din into the
//               slot that is read out on o_dout, so o_dout always presents the
//               sample written DEPTH enables earlier. Storage is not reset.
// Ports       : clk, rst    - clock, asynchronous active-high reset (pointer)
//               i_en         - advance the delay by one sample
//               i_din        - sample entering the delay
//               o_dout       - sample that entered DEPTH enables ago
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import laplace_pkg::*;
#(
    parameter int DEPTH = DEF_COLS - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);

    localparam int            PW         = cnt_w(DEPTH);
    localparam logic [PW-1:0] c_ptr_last = PW'(DEPTH - 1);

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
        end
    end

    // Read-before-write on the same slot: the oldest entry leaves as the
    // newest one takes its place.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    assign o_dout = r_mem[r_ptr];

endmodule : line_buffer
`default_nettype wire

// File: rtl/laplace_window.sv
`default_nettype none
// ============================================================================
// Module      : laplace_window
// Description : Streams a raster-order image and emits, for every pixel, the
//               4-neighbour cross window (north, west, centre, east, south)
//               with zero padding outside the frame. The window for centre m
//               is emitted when sample m+COLS arrives; the last COLS windows
//               of a frame are produced in a FLUSH phase that injects zeros.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               in_valid / in_ready   - input handshake
//               in_pixel              - raster-order pixel
//               out_valid             - one-cycle pulse per window
//               b, d, e, f, h         - north, west, centre, east, south
//               out_last              - window of the final frame pixel
// Revision    : 1.0 - initial release
// ============================================================================
module laplace_window
    import laplace_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
    output logic             out_last
);

    localparam int            CW         = cnt_w(COLS);
    localparam int            RW         = cnt_w(ROWS);
    localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);
    localparam logic [RW-1:0] c_row_last = RW'(ROWS - 1);
    // Centre row of the window emitted with the frame's final input sample.
    localparam logic [RW-1:0] c_row_pen  = RW'((ROWS > 1) ? (ROWS - 2) : 0);
    localparam bit            c_one_row  = (ROWS == 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ready;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_tap_e;
    logic [PIX_W-1:0] r_tap_d;

    logic             w_accept;
    logic             w_flush;
    logic             w_shift;
    logic             w_emit;
    logic             w_step_col;
    logic             w_col_end;
    logic             w_row_end;
    logic [PIX_W-1:0] w_din;
    logic [PIX_W-1:0] w_tap_f;
    logic [PIX_W-1:0] w_tap_b;
    logic [PIX_W-1:0] w_b;
    logic [PIX_W-1:0] w_d;
    logic [PIX_W-1:0] w_f;
    logic [PIX_W-1:0] w_h;

    // ------------------------------------------------------------------
    // Handshake and sample stream
    // ------------------------------------------------------------------
    assign in_ready   = r_ready;
    assign w_accept   = in_valid & r_ready;
    assign w_flush    = (r_state == ST_FLUSH);
    assign w_shift    = w_accept | w_flush;
    assign w_emit     = ((r_state == ST_RUN) & w_accept) | w_flush;
    assign w_step_col = ((r_state == ST_FILL) & w_accept) | w_emit;
    assign w_din      = w_flush ? '0 : in_pixel;
    assign w_col_end  = (r_col == c_col_last);
    assign w_row_end  = (r_row == c_row_last);

    // ------------------------------------------------------------------
    // Row history. With the newest sample n at the input:
    //   u_lb_f output = pix(n-COLS+1)  east neighbour of centre n-COLS
    //   r_tap_e       = pix(n-COLS)    centre
    //   r_tap_d       = pix(n-COLS-1)  west neighbour
    //   u_lb_b output = pix(n-2*COLS)  north neighbour
    // Each buffer plus its following tap register spans one full row.
    // ------------------------------------------------------------------
    line_buffer #(
        .DEPTH (COLS - 1)
    ) u_lb_f (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift),
        .i_din  (w_din),
        .o_dout (w_tap_f)
    );

    line_buffer #(
        .DEPTH (COLS - 1)
    ) u_lb_b (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift),
        .i_din  (r_tap_d),
        .o_dout (w_tap_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap_e <= '0;
            r_tap_d <= '0;
        end else if (w_shift) begin
            r_tap_e <= w_tap_f;
            r_tap_d <= r_tap_e;
        end
    end

    // ------------------------------------------------------------------
    // Position counters. During FILL r_col counts stored samples; from RUN
    // onwards r_col/r_row track the centre of the window being emitted, so
    // they wrap back to (0,0) exactly as the frame's last window leaves.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (w_step_col) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
            end
            if (w_emit && w_col_end) begin
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_col_end) begin
                    w_state_nxt = c_one_row ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && w_col_end && (r_row == c_row_pen)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_col_end) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // in_ready is registered from the next state so it is low throughout
    // reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt != ST_FLUSH);
        end
    end

    // ------------------------------------------------------------------
    // Zero padding: masking by centre position also hides stale line-buffer
    // contents left over from a previous or abandoned frame.
    // ------------------------------------------------------------------
    assign w_b = (r_row == '0) ? '0 : w_tap_b;
    assign w_d = (r_col == '0) ? '0 : r_tap_d;
    assign w_f = w_col_end     ? '0 : w_tap_f;
    assign w_h = w_row_end     ? '0 : w_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            b         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            h         <= '0;
        end else begin
            out_valid <= w_emit;
            out_last  <= w_emit & w_col_end & w_row_end;
            if (w_emit) begin
                b <= w_b;
                d <= w_d;
                e <= r_tap_e;
                f <= w_f;
                h <= w_h;
            end
        end
    end

endmodule : laplace_window
`default_nettype wire

// File: tb/tb_laplace_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_laplace_window
// Description : Directed bench for laplace_window at COLS=4, ROWS=3 with
//               pixel value n+1. Covers reset, back-to-back and gapped
//               streams, flush timing, out_last, and reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laplace_window;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int NPIX = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] b, d, e, f, h;
    logic       out_last;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [39:0] win  [16];
    logic        wlast[16];
    int          wcyc [16];
    int          acc_cyc[16];
    int          widx = 0;
    int          rlow = 0;

    laplace_window #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .b         (b),
        .d         (d),
        .e         (e),
        .f         (f),
        .h         (h),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every window and count not-ready cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && widx < 16) begin
                win[widx]   = {b, d, e, f, h};
                wlast[widx] = out_last;
                wcyc[widx]  = cyc;
                widx++;
            end
            if (!in_ready) rlow++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference cross window for centre m with pix(r,c) = r*COLS + c + 1.
    function automatic logic [39:0] exp_win(input int m);
        int r, c;
        logic [7:0] pb, pd, pe, pf, ph;
        r  = m / COLS;
        c  = m % COLS;
        pe = 8'(m + 1);
        pb = (r == 0)        ? 8'd0 : 8'(m - COLS + 1);
        ph = (r == ROWS - 1) ? 8'd0 : 8'(m + COLS + 1);
        pd = (c == 0)        ? 8'd0 : 8'(m);
        pf = (c == COLS - 1) ? 8'd0 : 8'(m + 2);
        return {pb, pd, pe, pf, ph};
    endfunction

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, 64'(in_ready), 64'd0);
        check({nm, "_valid"}, 64'(out_valid), 64'd0);
        check({nm, "_last"},  64'(out_last), 64'd0);
        check({nm, "_win"},   64'({b, d, e, f, h}), 64'd0);
    endtask

    task automatic release_reset(input string nm);
        @(posedge clk);
        #2 rst = 1'b0;
        check({nm, "_ready_pre"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 check({nm, "_ready_rise"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_frame(input bit toggle, input string nm);
        int  n     = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        bit  acc;
        for (int i = 0; i < 16; i++) win[i] = '0;
        widx = 0;
        rlow = 0;
        while (n < NPIX && guard < 200) begin
            @(negedge clk);
            in_valid = toggle ? !phase : 1'b1;
            phase    = !phase;
            in_pixel = 8'(n + 1);
            acc      = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[n] = cyc;
                n++;
            end
            guard++;
        end
        check({nm, "_accepts"}, 64'(n), 64'(NPIX));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check({nm, "_count"}, 64'(widx), 64'(NPIX));
        check({nm, "_ready_low"}, 64'(rlow), 64'(COLS));
        for (int m = 0; m < NPIX; m++) begin
            check($sformatf("%s_win%0d", nm, m), 64'(win[m]), 64'(exp_win(m)));
            check($sformatf("%s_last%0d", nm, m), 64'(wlast[m]), 64'(m == NPIX - 1));
            if (m < NPIX - COLS)
                check($sformatf("%s_cyc%0d", nm, m), 64'(wcyc[m]), 64'(acc_cyc[m + COLS]));
            else
                check($sformatf("%s_cyc%0d", nm, m), 64'(wcyc[m]),
                      64'(acc_cyc[NPIX - 1] + m - (NPIX - COLS - 1)));
        end
        #1;
        check({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({nm, "_hold"}, 64'({b, d, e, f, h}), 64'h08_0B_0C_00_00);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        release_reset("por");

        run_frame(1'b0, "b2b");
        run_frame(1'b1, "gap");

        // Abandon a frame after 7 acceptances.
        begin
            int n = 0;
            int guard = 0;
            bit acc;
            while (n < 7 && guard < 50) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_pixel = 8'(n + 1);
                acc      = in_ready;
                @(posedge clk);
                if (acc) n++;
                guard++;
            end
            check("mid_accepts", 64'(n), 64'd7);
        end
        @(negedge clk);
        check("mid_win_before", 64'({b, d, e, f, h}), 64'(exp_win(2)));
        rst      = 1'b1;
        in_valid = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        release_reset("mid");

        run_frame(1'b0, "fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_laplace_window
`default_nettype wire
